// File: rtl/uart_pkg.sv
// Shared types and constants for the oversampled UART blocks.
//   parity_e        : runtime parity selection (cfg_parity encoding)
//   uart_rx_state_e : receiver FSM states
//   OS_RATE / SAMPLE_* : oversampling rate and majority-vote sample points
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE  = 2'd0,
    PAR_ODD   = 2'd1,
    PAR_EVEN  = 2'd2,
    PAR_NONE2 = 2'd3
  } parity_e;

  localparam int unsigned OS_RATE    = 16;
  localparam int unsigned SAMPLE_LO  = 7;
  localparam int unsigned SAMPLE_MID = 8;
  localparam int unsigned SAMPLE_HI  = 9;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    STOP2,
    WAIT_HIGH
  } uart_rx_state_e;

  function automatic logic maj3(logic a, logic b, logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: a prescaler counting 0..div and a 4-bit subtick counter
// that advances (wrapping 15->0) on each tick.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : restart prescaler and subtick from 0 (no tick in this cycle)
//   div        : tick every div+1 clocks
//   tick       : one-cycle strobe when the prescaler reaches div
//   subtick    : current subtick position within the bit
module uart_baud_tick #(
  parameter int unsigned DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic [DIV_WIDTH-1:0] div,
  output logic                 tick,
  output logic [3:0]           subtick
);

  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [3:0]           sub_q, sub_d;

  assign tick    = !clear && (cnt_q == div);
  assign subtick = sub_q;

  always_comb begin
    cnt_d = cnt_q + DIV_WIDTH'(1);
    sub_d = sub_q;
    if (clear) begin
      cnt_d = '0;
      sub_d = '0;
    end else if (tick) begin
      cnt_d = '0;
      sub_d = sub_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      sub_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      sub_q <= sub_d;
    end
  end

endmodule

// File: rtl/uart_rx_os.sv
// 16x-oversampling UART receiver with runtime divisor/parity/stop configuration,
// 3-sample majority vote per bit and a single-entry valid/ready output register.
//   clk, rst_n        : clock, asynchronous active-low reset
//   cfg_div           : oversample tick every cfg_div+1 clocks (latched at start edge)
//   cfg_parity        : 0/3 none, 1 odd, 2 even (latched at start edge)
//   cfg_stop2         : expect two stop bits (latched at start edge)
//   rx_in             : asynchronous serial line, idle high
//   m_valid/m_ready   : output handshake; m_data and flags describe the held frame
//   m_parity_err      : parity mismatch
//   m_frame_err       : a required stop bit was low (also set on break)
//   m_break           : data, parity and first stop bit all low
//   overrun           : one-cycle pulse when a completed frame could not be stored
//   busy              : FSM not idle
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned DIV_WIDTH   = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DIV_WIDTH-1:0] cfg_div,
  input  logic [1:0]           cfg_parity,
  input  logic                 cfg_stop2,
  input  logic                 rx_in,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [DATA_BITS-1:0] m_data,
  output logic                 m_parity_err,
  output logic                 m_frame_err,
  output logic                 m_break,
  output logic                 overrun,
  output logic                 busy
);

  localparam int unsigned CntW = $clog2(DATA_BITS + 1);
  // The tick that moves subtick to N sees subtick == N-1 beforehand.
  localparam logic [3:0] SubLo   = 4'(SAMPLE_LO - 1);
  localparam logic [3:0] SubMid  = 4'(SAMPLE_MID - 1);
  localparam logic [3:0] SubHi   = 4'(SAMPLE_HI - 1);
  localparam logic [3:0] SubLast = 4'(OS_RATE - 1);

  // Input synchroniser, preset to idle level.
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s, rx_prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= '1;
      rx_prev_q <= 1'b1;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], rx_in};
      rx_prev_q <= rx_s;
    end
  end

  assign rx_s = sync_q[SYNC_STAGES-1];

  uart_rx_state_e       state_q, state_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  parity_e              par_q, par_d;
  logic                 stop2_q, stop2_d;
  logic                 s_lo_q, s_mid_q;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [CntW-1:0]      bit_cnt_q, bit_cnt_d;
  logic                 par_bit_q, par_bit_d;
  logic                 stop1_q, stop1_d;
  logic                 pe_q, pe_d;
  logic                 fe_q, fe_d;

  logic       start_edge, tick, decide, wrap, bit_val, par_en;
  logic [3:0] subtick;
  logic       done, done_brk, stop1_now;

  assign start_edge = (state_q == IDLE) && rx_prev_q && !rx_s;
  assign decide     = tick && (subtick == SubHi);
  assign wrap       = tick && (subtick == SubLast);
  assign bit_val    = maj3(s_lo_q, s_mid_q, rx_s);
  assign par_en     = (par_q == PAR_ODD) || (par_q == PAR_EVEN);

  uart_baud_tick #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_baud_tick (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (start_edge),
    .div     (div_q),
    .tick    (tick),
    .subtick (subtick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_lo_q  <= 1'b1;
      s_mid_q <= 1'b1;
    end else begin
      if (tick && (subtick == SubLo))  s_lo_q  <= rx_s;
      if (tick && (subtick == SubMid)) s_mid_q <= rx_s;
    end
  end

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    par_d     = par_q;
    stop2_d   = stop2_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    par_bit_d = par_bit_q;
    stop1_d   = stop1_q;
    pe_d      = pe_q;
    fe_d      = fe_q;
    done      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_edge) begin
          state_d   = START;
          div_d     = cfg_div;
          par_d     = parity_e'(cfg_parity);
          stop2_d   = cfg_stop2;
          bit_cnt_d = '0;
          pe_d      = 1'b0;
          fe_d      = 1'b0;
        end
      end
      START: begin
        if (decide && bit_val) begin
          state_d = IDLE;
        end else if (wrap) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (decide) begin
          shift_d   = {bit_val, shift_q[DATA_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + CntW'(1);
          if (bit_cnt_q == CntW'(DATA_BITS - 1)) begin
            state_d = par_en ? PARITY : STOP;
          end
        end
      end
      PARITY: begin
        if (decide) begin
          par_bit_d = bit_val;
          // XOR of data and parity bit is 1 when the total ones count is odd.
          pe_d      = (par_q == PAR_ODD) ? !(^shift_q ^ bit_val) : (^shift_q ^ bit_val);
          state_d   = STOP;
        end
      end
      STOP: begin
        if (decide) begin
          stop1_d = bit_val;
          fe_d    = fe_q | !bit_val;
          if (stop2_q) begin
            state_d = STOP2;
          end else begin
            done    = 1'b1;
            state_d = bit_val ? IDLE : WAIT_HIGH;
          end
        end
      end
      STOP2: begin
        if (decide) begin
          fe_d    = fe_q | !bit_val;
          done    = 1'b1;
          state_d = bit_val ? IDLE : WAIT_HIGH;
        end
      end
      WAIT_HIGH: begin
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign stop1_now = (state_q == STOP) ? bit_val : stop1_q;
  assign done_brk  = (shift_q == '0) && !(par_en && par_bit_q) && !stop1_now;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      div_q     <= '0;
      par_q     <= PAR_NONE;
      stop2_q   <= 1'b0;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      par_bit_q <= 1'b0;
      stop1_q   <= 1'b1;
      pe_q      <= 1'b0;
      fe_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      par_q     <= par_d;
      stop2_q   <= stop2_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      par_bit_q <= par_bit_d;
      stop1_q   <= stop1_d;
      pe_q      <= pe_d;
      fe_q      <= fe_d;
    end
  end

  // Output holding register: a freed or empty slot takes the frame, otherwise it is dropped.
  logic m_valid_q, m_valid_d, load, overrun_q;

  assign load      = done && (!m_valid_q || m_ready);
  assign m_valid_d = load ? 1'b1 : ((m_valid_q && m_ready) ? 1'b0 : m_valid_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid_q    <= 1'b0;
      overrun_q    <= 1'b0;
      m_data       <= '0;
      m_parity_err <= 1'b0;
      m_frame_err  <= 1'b0;
      m_break      <= 1'b0;
    end else begin
      m_valid_q <= m_valid_d;
      overrun_q <= done && !load;
      if (load) begin
        m_data       <= shift_q;
        m_parity_err <= pe_q;
        m_frame_err  <= fe_d | done_brk;
        m_break      <= done_brk;
      end
    end
  end

  assign m_valid = m_valid_q;
  assign overrun = overrun_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_os.sv
module tb_uart_rx_os;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] cfg_div = 16'd26;
  logic [1:0]  cfg_parity = 2'd0;
  logic        cfg_stop2 = 1'b0;
  logic        rx_in = 1'b1;
  logic        m_ready = 1'b1;
  logic        m_valid, m_parity_err, m_frame_err, m_break, overrun, busy;
  logic [7:0]  m_data;

  uart_rx_os dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_div      (cfg_div),
    .cfg_parity   (cfg_parity),
    .cfg_stop2    (cfg_stop2),
    .rx_in        (rx_in),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .m_parity_err (m_parity_err),
    .m_frame_err  (m_frame_err),
    .m_break      (m_break),
    .overrun      (overrun),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] data;
    logic       pe;
    logic       fe;
    logic       brk;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   valid_cycles = 0;
  int   ovr_cycles = 0;
  int   rise_cyc = -1;
  int   start_cyc = 0;
  logic valid_prev = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: count activity and score every transfer.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (rst_n) begin
      if (m_valid) valid_cycles++;
      if (overrun) ovr_cycles++;
      if (m_valid && !valid_prev) rise_cyc = cyc;
      if (m_valid && m_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_xfer", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("xfer_data", 32'(m_data), 32'(e.data));
          check("xfer_parity_err", 32'(m_parity_err), 32'(e.pe));
          check("xfer_frame_err", 32'(m_frame_err), 32'(e.fe));
          check("xfer_break", 32'(m_break), 32'(e.brk));
        end
      end
    end
    valid_prev = m_valid;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick_n(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic v, input int n);
    rx_in = v;
    tick_n(n);
  endtask

  // Sends one frame at the current cfg_div; gbit selects a data bit that gets a one-tick
  // low glitch around its middle sample (offsets assume cfg_div=26).
  task automatic send(input logic [7:0] d, input logic [1:0] pm, input logic s2,
                      input logic pbit, input logic s2val, input int gbit, input logic push);
    int   bl;
    logic pen;
    exp_t e;
    bl         = 16 * (int'(cfg_div) + 1);
    pen        = (pm == 2'd1) || (pm == 2'd2);
    cfg_parity = pm;
    cfg_stop2  = s2;
    if (push) begin
      e.data = d;
      e.pe   = pen && ((^d ^ pbit) != (pm == 2'd1));
      e.fe   = s2 && !s2val;
      e.brk  = 1'b0;
      sb.push_back(e);
    end
    start_cyc = cyc;
    drive(1'b0, bl);
    for (int i = 0; i < 8; i++) begin
      if (i == gbit) begin
        drive(d[i], 205);
        drive(1'b0, 27);
        drive(d[i], bl - 232);
      end else begin
        drive(d[i], bl);
      end
    end
    if (pen) drive(pbit, bl);
    drive(1'b1, bl);
    if (s2) drive(s2val, bl);
    rx_in = 1'b1;
  endtask

  initial begin
    int   vc0;
    int   oc0;
    exp_t e;

    tick_n(3);
    check("rst_valid", 32'(m_valid), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_data", 32'(m_data), 32'd0);
    check("rst_flags", {29'd0, m_parity_err, m_frame_err, m_break}, 32'd0);
    rst_n = 1'b1;
    tick_n(5);

    // 8N1 at div 26: latency = sync + edge + 153 ticks of 27 clocks.
    vc0 = valid_cycles;
    send(8'hA5, 2'd0, 1'b0, 1'b0, 1'b1, -1, 1'b1);
    tick_n(20);
    check("a5_latency", 32'(rise_cyc - start_cyc), 32'(2 + 1 + 27 * 153));
    check("a5_valid_cycles", 32'(valid_cycles - vc0), 32'd1);

    // One-tick glitch at the middle sample of data bit 3 is outvoted.
    send(8'hFF, 2'd0, 1'b0, 1'b0, 1'b1, 3, 1'b1);
    tick_n(20);

    // Short low pulse on idle line is a false start.
    vc0   = valid_cycles;
    rx_in = 1'b0;
    tick_n(27);
    rx_in = 1'b1;
    tick_n(10);
    check("glitch_busy_start", 32'(busy), 32'd1);
    tick_n(300);
    check("glitch_busy_end", 32'(busy), 32'd0);
    check("glitch_no_valid", 32'(valid_cycles - vc0), 32'd0);

    cfg_div = 16'd7;
    tick_n(5);

    // Odd parity on 0x07 (three ones): parity bit 0 is correct, 1 is a mismatch.
    send(8'h07, 2'd1, 1'b0, 1'b0, 1'b1, -1, 1'b1);
    send(8'h07, 2'd1, 1'b0, 1'b1, 1'b1, -1, 1'b1);
    tick_n(20);

    // Break: line low for two 8E1 frame times.
    cfg_parity = 2'd2;
    cfg_stop2  = 1'b0;
    vc0        = valid_cycles;
    e.data = 8'h00;
    e.pe   = 1'b0;
    e.fe   = 1'b1;
    e.brk  = 1'b1;
    sb.push_back(e);
    drive(1'b0, 2 * 11 * 128);
    check("brk_busy_low", 32'(busy), 32'd1);
    check("brk_delivered", 32'(sb.size()), 32'd0);
    check("brk_single", 32'(valid_cycles - vc0), 32'd1);
    drive(1'b1, 256);
    check("brk_busy_high", 32'(busy), 32'd0);
    send(8'h3C, 2'd2, 1'b0, 1'b0, 1'b1, -1, 1'b1);
    tick_n(20);

    // Overrun: consumer stalled across two back-to-back frames.
    m_ready = 1'b0;
    oc0     = ovr_cycles;
    send(8'h11, 2'd0, 1'b0, 1'b0, 1'b1, -1, 1'b1);
    send(8'h22, 2'd0, 1'b0, 1'b0, 1'b1, -1, 1'b0);
    tick_n(10);
    check("ovr_pulse", 32'(ovr_cycles - oc0), 32'd1);
    check("ovr_hold_data", 32'(m_data), 32'h11);
    check("ovr_hold_valid", 32'(m_valid), 32'd1);
    m_ready = 1'b1;
    tick_n(5);
    check("ovr_drained", 32'(sb.size()), 32'd0);
    check("ovr_valid_clear", 32'(m_valid), 32'd0);

    // Two stop bits, second one low.
    send(8'h81, 2'd0, 1'b1, 1'b0, 1'b0, -1, 1'b1);
    tick_n(50);

    // Reset in the middle of the data bits.
    oc0 = ovr_cycles;
    vc0 = valid_cycles;
    cfg_parity = 2'd0;
    cfg_stop2  = 1'b0;
    drive(1'b0, 128);
    drive(1'b0, 128);
    drive(1'b1, 128);
    check("rstmid_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    rx_in = 1'b1;
    tick_n(3);
    check("rstmid_valid", 32'(m_valid), 32'd0);
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_overrun", 32'(overrun), 32'd0);
    rst_n = 1'b1;
    tick_n(1500);
    check("rstmid_no_ovr", 32'(ovr_cycles - oc0), 32'd0);
    check("rstmid_no_valid", 32'(valid_cycles - vc0), 32'd0);
    check("rstmid_idle", 32'(busy), 32'd0);
    send(8'h5A, 2'd0, 1'b0, 1'b0, 1'b1, -1, 1'b1);

    for (int i = 0; i < 2000 && sb.size() != 0; i++) tick_n(1);
    tick_n(10);
    check("sb_drain", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
